mix_columns_iter: RTL and testbench

- Iterative AES MixColumns stage.
- Sits directly downstream of the ShiftRows stage and consumes its 128-bit shifted state.
- Processes one 4-byte column per clock, so four GF(2^8) column units are not needed.
- Uses the same en/done handshake and state byte ordering as the rest of the round datapath.

---
 rtl/mix_columns_iter.sv | 152 +++++++++++++++
 tb/tb_mix_columns_iter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage, one 4-byte column per clock.
// Byte k of the state sits at bits [k*8 +: 8] of a [0:127] vector (bit 0 = MSB of
// byte 0), with k = 4*col + row, matching the rest of the round datapath.
// Optional build macro MIX_COLUMNS_INV_EN adds an 'inv' input that selects
// InvMixColumns for the block latched at the start edge.
module mix_columns_iter #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
`ifdef MIX_COLUMNS_INV_EN
    input  logic                             inv,
`endif
    input  logic [0:word_size*array_size-1]  Data,
    output logic [0:word_size*array_size-1]  Mixed_Data,
    output logic                             busy,
    output logic                             done
);

    localparam int STATE_W = word_size * array_size;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column mix; column packed as {a0, a1, a2, a3} with a0 in the top byte.
    function automatic logic [31:0] fwd_mix(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        return {d0 ^ (d1 ^ a1) ^ a2 ^ a3,
                a0 ^ d1 ^ (d2 ^ a2) ^ a3,
                a0 ^ a1 ^ d2 ^ (d3 ^ a3),
                (d0 ^ a0) ^ a1 ^ a2 ^ d3};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse column mix; 9x, bx, dx, ex are assembled from x, 2x, 4x and 8x.
    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    logic [0:0]          state_r;
    logic [1:0]          col_r;
    logic [0:STATE_W-1]  work_r;
    logic [31:0]         col_in_s;
    logic [31:0]         col_out_s;
    logic [0:STATE_W-1]  next_work_s;
`ifdef MIX_COLUMNS_INV_EN
    logic                inv_r;
`endif

    // Mix the column selected by col_r and merge it back into a copy of the work state.
    always_comb begin
        col_in_s = work_r[{col_r, 5'd0} +: 32];
`ifdef MIX_COLUMNS_INV_EN
        if (inv_r) begin
            col_out_s = inv_mix(col_in_s);
        end else begin
            col_out_s = fwd_mix(col_in_s);
        end
`else
        col_out_s = fwd_mix(col_in_s);
`endif
        next_work_s = work_r;
        next_work_s[{col_r, 5'd0} +: 32] = col_out_s;
    end

    // Control FSM, column counter, work register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            col_r      <= 2'd0;
            work_r     <= {STATE_W{1'b0}};
            Mixed_Data <= {STATE_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_r      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        work_r  <= Data;
                        col_r   <= 2'd0;
                        state_r <= RUN;
                        busy    <= 1'b1;
`ifdef MIX_COLUMNS_INV_EN
                        inv_r   <= inv;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    work_r <= next_work_s;
                    if (col_r == 2'd3) begin
                        // Last column: publish the finished state and return to idle.
                        Mixed_Data <= next_work_s;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                        col_r      <= 2'd0;
                    end else begin
                        col_r <= col_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    col_r   <= 2'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter. Expected states come from constants
// and a generic GF(2^8) multiply model; results are queued at start and popped
// when done pulses. Build with MIX_COLUMNS_INV_EN to exercise the inverse path.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [0:127] data;
    logic [0:127] mixed;
    logic         busy;
    logic         done;
`ifdef MIX_COLUMNS_INV_EN
    logic         inv;
`endif

    int           n_checks = 0;
    int           n_fails  = 0;
    logic [0:127] exp_q[$];

    always #5 clk = ~clk;

    mix_columns_iter dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef MIX_COLUMNS_INV_EN
        .inv        (inv),
`endif
        .Data       (data),
        .Mixed_Data (mixed),
        .busy       (busy),
        .done       (done)
    );

    // Carry-less multiply followed by reduction modulo 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (15'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (15'h11b << (k - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [0:127] model_mix(input logic [0:127] d, input bit iv);
        logic [7:0]   fw [4];
        logic [7:0]   iw [4];
        logic [7:0]   a  [4];
        logic [7:0]   acc;
        logic [7:0]   coef;
        logic [0:127] r;
        fw = '{8'h02, 8'h03, 8'h01, 8'h01};
        iw = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        r  = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) a[rr] = d[(4*c+rr)*8 +: 8];
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    coef = iv ? iw[(j - rr + 4) % 4] : fw[(j - rr + 4) % 4];
                    acc  = acc ^ gmul(coef, a[j]);
                end
                r[(4*c+rr)*8 +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one start request; returns just after the accepting edge.
    task automatic drive_start(input logic [0:127] d, input logic [0:127] e);
        en   = 1'b1;
        data = d;
`ifdef MIX_COLUMNS_INV_EN
        inv  = 1'b0;
`endif
        exp_q.push_back(e);
        step();
        en = 1'b0;
    endtask

    // Bounded wait for done; optionally scrambles Data while the block runs.
    task automatic wait_done(input int budget, input bit scramble, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            if (scramble) data = rand128();
            step();
            cycles++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    function automatic logic [0:127] pop_exp();
        if (exp_q.size() == 0) return 128'hx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst  = 1'b0;
        en   = 1'b0;
        data = 128'h0;
        for (int i = 0; i < 3; i++) begin
            en   = ~en;
            data = rand128();
            step();
            n_checks++;
            if (mixed !== 128'h0) begin n_fails++; $display("FAIL reset_mixed: got %h expected 0", mixed); end
            n_checks++;
            if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
            n_checks++;
            if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", done); end
        end
        en  = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fails++; $display("FAIL reset_release: got busy/done %b expected 00", {busy, done}); end
    endtask

    task automatic test_fips();
        logic [0:127] e;
        drive_start(128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h046681e5e0cb199a48f8d37a2806264c);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_fails++; $display("FAIL fips_busy_window: cycle %0d busy/done %b expected 10", k, {busy, done});
            end
            step();
        end
        e = pop_exp();
        n_checks++;
        if (done !== 1'b1) begin n_fails++; $display("FAIL fips_done: got %b expected 1", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL fips_busy_end: got %b expected 0", busy); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL fips_result: got %h expected %h", mixed, e); end
        step();
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL fips_done_pulse: got %b expected 0", done); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL fips_hold: got %h expected %h", mixed, e); end
    endtask

    task automatic test_fixed_points();
        bit           seen;
        int           cyc;
        logic [0:127] e;
        drive_start(128'h01010101c6c6c6c6d4d4d4d52d26314c, 128'h01010101c6c6c6c6d5d5d7d64d7ebdf8);
        wait_done(8, 1'b1, seen, cyc);
        e = pop_exp();
        n_checks++;
        if (!seen || cyc != 4) begin n_fails++; $display("FAIL fixed_latency: seen %b cycles %0d expected 4", seen, cyc); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL fixed_result: got %h expected %h", mixed, e); end
    endtask

    task automatic test_busy_lockout();
        logic [0:127] va, vb, e;
        bit           seen;
        int           cyc;
        va = rand128();
        vb = rand128();
        drive_start(va, model_mix(va, 1'b0));
        step();
        en   = 1'b1;
        data = vb;
        step();
        en   = 1'b0;
        data = rand128();
        n_checks++;
        if ({busy, done} !== 2'b10) begin n_fails++; $display("FAIL lockout_busy: busy/done %b expected 10", {busy, done}); end
        step();
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL lockout_early_done: got %b expected 0", done); end
        step();
        e = pop_exp();
        n_checks++;
        if (done !== 1'b1) begin n_fails++; $display("FAIL lockout_done: got %b expected 1", done); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL lockout_result_a: got %h expected %h", mixed, e); end
        drive_start(vb, model_mix(vb, 1'b0));
        n_checks++;
        if (busy !== 1'b1) begin n_fails++; $display("FAIL lockout_accept_in_done: busy %b expected 1", busy); end
        wait_done(8, 1'b1, seen, cyc);
        e = pop_exp();
        n_checks++;
        if (!seen || cyc != 4) begin n_fails++; $display("FAIL lockout_b_latency: seen %b cycles %0d expected 4", seen, cyc); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL lockout_result_b: got %h expected %h", mixed, e); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({busy, done} !== 2'b00) begin n_fails++; $display("FAIL lockout_no_queue: busy/done %b expected 00", {busy, done}); end
        end
    endtask

    task automatic test_midop_reset();
        logic [0:127] vc, e;
        bit           seen;
        int           cyc;
        vc   = rand128();
        en   = 1'b1;
        data = rand128();
        step();
        en = 1'b0;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (mixed !== 128'h0) begin n_fails++; $display("FAIL midreset_mixed: got %h expected 0", mixed); end
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fails++; $display("FAIL midreset_flags: busy/done %b expected 00", {busy, done}); end
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({busy, done} !== 2'b00) begin n_fails++; $display("FAIL midreset_no_done: busy/done %b expected 00", {busy, done}); end
        end
        drive_start(vc, model_mix(vc, 1'b0));
        wait_done(8, 1'b0, seen, cyc);
        e = pop_exp();
        n_checks++;
        if (!seen || cyc != 4) begin n_fails++; $display("FAIL midreset_restart_latency: seen %b cycles %0d expected 4", seen, cyc); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL midreset_restart_result: got %h expected %h", mixed, e); end
    endtask

    task automatic test_back_to_back();
        logic [0:127] v [6];
        logic [0:127] e;
        bit           seen;
        int           cyc;
        for (int i = 0; i < 6; i++) v[i] = rand128();
        drive_start(v[0], model_mix(v[0], 1'b0));
        for (int i = 0; i < 6; i++) begin
            wait_done(8, 1'b1, seen, cyc);
            e = pop_exp();
            n_checks++;
            if (!seen || cyc != 4) begin n_fails++; $display("FAIL b2b_latency[%0d]: seen %b cycles %0d expected 4", i, seen, cyc); end
            n_checks++;
            if (mixed !== e) begin n_fails++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, mixed, e); end
            if (i < 5) drive_start(v[i+1], model_mix(v[i+1], 1'b0));
        end
    endtask

`ifdef MIX_COLUMNS_INV_EN
    task automatic test_inverse();
        logic [0:127] vr, e;
        bit           seen;
        int           cyc;
        en   = 1'b1;
        inv  = 1'b1;
        data = 128'h046681e5e0cb199a48f8d37a2806264c;
        exp_q.push_back(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        step();
        en  = 1'b0;
        inv = 1'b0;
        wait_done(8, 1'b1, seen, cyc);
        e = pop_exp();
        n_checks++;
        if (!seen || cyc != 4) begin n_fails++; $display("FAIL inv_latency: seen %b cycles %0d expected 4", seen, cyc); end
        n_checks++;
        if (mixed !== e) begin n_fails++; $display("FAIL inv_fips: got %h expected %h", mixed, e); end
        vr   = rand128();
        en   = 1'b1;
        inv  = 1'b1;
        data = model_mix(vr, 1'b0);
        exp_q.push_back(vr);
        step();
        en = 1'b0;
        wait_done(8, 1'b1, seen, cyc);
        e = pop_exp();
        n_checks++;
        if (!seen || mixed !== e) begin n_fails++; $display("FAIL inv_roundtrip: got %h expected %h", mixed, e); end
    endtask
`endif

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        data = 128'h0;
`ifdef MIX_COLUMNS_INV_EN
        inv  = 1'b0;
`endif
        test_reset();
        test_fips();
        test_fixed_points();
        test_busy_lockout();
        test_midop_reset();
        test_back_to_back();
`ifdef MIX_COLUMNS_INV_EN
        test_inverse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
